// File: rtl/axi_addr_split_pkg.sv
// Shared definitions for the AXI3 address-decode splitter.
// Holds the response encodings, the FSM state encodings, the decode target
// and the default address windows used by axi_addr_split and axi_addr_decode.
package axi_addr_split_pkg;

  localparam int L_LEN_W   = 4;
  localparam int L_SIZE_W  = 3;
  localparam int L_BURST_W = 2;
  localparam int L_LOCK_W  = 2;
  localparam int L_CACHE_W = 4;
  localparam int L_PROT_W  = 3;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [31:0] SRAM_BASE_DEF = 32'h0000_0000;
  localparam logic [31:0] SRAM_SIZE_DEF = 32'h0000_8000;
  localparam logic [31:0] MMIO_BASE_DEF = 32'h1FD0_0000;
  localparam logic [31:0] MMIO_SIZE_DEF = 32'h0001_0000;

  typedef enum logic [1:0] {RD_IDLE, RD_ADDR, RD_DATA, RD_ERR} rd_state_t;
  typedef enum logic [2:0] {WR_IDLE, WR_ADDR, WR_DATA, WR_RESP, WR_ERR, WR_ERRB} wr_state_t;
  typedef enum logic [1:0] {TGT_M0, TGT_M1, TGT_ERR} tgt_t;

  // M0 wins when both windows hit.
  function automatic tgt_t pick_target(input logic hit0, input logic hit1, input logic err);
    if (err) return TGT_ERR;
    if (hit0) return TGT_M0;
    return hit1 ? TGT_M1 : TGT_ERR;
  endfunction

endpackage

// File: rtl/axi_addr_decode.sv
// Combinational address-window decode.
// Ports: addr in; hit0 (SRAM window), hit1 (MMIO window), err (neither) out.
module axi_addr_decode
  import axi_addr_split_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] SRAM_BASE = SRAM_BASE_DEF,
  parameter logic [ADDR_W-1:0] SRAM_SIZE = SRAM_SIZE_DEF,
  parameter logic [ADDR_W-1:0] MMIO_BASE = MMIO_BASE_DEF,
  parameter logic [ADDR_W-1:0] MMIO_SIZE = MMIO_SIZE_DEF
) (
  input  logic [ADDR_W-1:0] addr,
  output logic              hit0,
  output logic              hit1,
  output logic              err
);

  // Window sizes are powers of two, so masking off the offset bits leaves the base.
  localparam logic [ADDR_W-1:0] SRAM_MASK = ~(SRAM_SIZE - ADDR_W'(1));
  localparam logic [ADDR_W-1:0] MMIO_MASK = ~(MMIO_SIZE - ADDR_W'(1));

  assign hit0 = (addr & SRAM_MASK) == SRAM_BASE;
  assign hit1 = (addr & MMIO_MASK) == MMIO_BASE;
  assign err  = ~hit0 & ~hit1;

endmodule

// File: rtl/axi_addr_split.sv
// Single-master, two-slave AXI3 address splitter.
// s_*  : CPU-facing slave port (AW/W/B/AR/R).
// m0_* : SRAM window port, m1_* : MMIO window port (directions mirrored).
// Addresses outside both windows complete locally with DECERR.
// One outstanding transaction per direction; read and write FSMs are independent.
// resetn is asynchronous and active-high.
module axi_addr_split
  import axi_addr_split_pkg::*;
#(
  parameter int                ID_W      = 4,
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 32,
  parameter logic [ADDR_W-1:0] SRAM_BASE = SRAM_BASE_DEF,
  parameter logic [ADDR_W-1:0] SRAM_SIZE = SRAM_SIZE_DEF,
  parameter logic [ADDR_W-1:0] MMIO_BASE = MMIO_BASE_DEF,
  parameter logic [ADDR_W-1:0] MMIO_SIZE = MMIO_SIZE_DEF
) (
  input  logic clk, input logic resetn,
  // CPU write address / data / response
  input  logic [ID_W-1:0] s_awid, input logic [ADDR_W-1:0] s_awaddr, input logic [3:0] s_awlen,
  input  logic [2:0] s_awsize, input logic [1:0] s_awburst, input logic [1:0] s_awlock,
  input  logic [3:0] s_awcache, input logic [2:0] s_awprot, input logic s_awvalid, output logic s_awready,
  input  logic [ID_W-1:0] s_wid, input logic [DATA_W-1:0] s_wdata, input logic [DATA_W/8-1:0] s_wstrb,
  input  logic s_wlast, input logic s_wvalid, output logic s_wready,
  output logic [ID_W-1:0] s_bid, output logic [1:0] s_bresp, output logic s_bvalid, input logic s_bready,
  // CPU read address / data
  input  logic [ID_W-1:0] s_arid, input logic [ADDR_W-1:0] s_araddr, input logic [3:0] s_arlen,
  input  logic [2:0] s_arsize, input logic [1:0] s_arburst, input logic [1:0] s_arlock,
  input  logic [3:0] s_arcache, input logic [2:0] s_arprot, input logic s_arvalid, output logic s_arready,
  output logic [ID_W-1:0] s_rid, output logic [DATA_W-1:0] s_rdata, output logic [1:0] s_rresp,
  output logic s_rlast, output logic s_rvalid, input logic s_rready,
  // M0 (SRAM)
  output logic [ID_W-1:0] m0_awid, output logic [ADDR_W-1:0] m0_awaddr, output logic [3:0] m0_awlen,
  output logic [2:0] m0_awsize, output logic [1:0] m0_awburst, output logic [1:0] m0_awlock,
  output logic [3:0] m0_awcache, output logic [2:0] m0_awprot, output logic m0_awvalid, input logic m0_awready,
  output logic [ID_W-1:0] m0_wid, output logic [DATA_W-1:0] m0_wdata, output logic [DATA_W/8-1:0] m0_wstrb,
  output logic m0_wlast, output logic m0_wvalid, input logic m0_wready,
  input  logic [ID_W-1:0] m0_bid, input logic [1:0] m0_bresp, input logic m0_bvalid, output logic m0_bready,
  output logic [ID_W-1:0] m0_arid, output logic [ADDR_W-1:0] m0_araddr, output logic [3:0] m0_arlen,
  output logic [2:0] m0_arsize, output logic [1:0] m0_arburst, output logic [1:0] m0_arlock,
  output logic [3:0] m0_arcache, output logic [2:0] m0_arprot, output logic m0_arvalid, input logic m0_arready,
  input  logic [ID_W-1:0] m0_rid, input logic [DATA_W-1:0] m0_rdata, input logic [1:0] m0_rresp,
  input  logic m0_rlast, input logic m0_rvalid, output logic m0_rready,
  // M1 (MMIO)
  output logic [ID_W-1:0] m1_awid, output logic [ADDR_W-1:0] m1_awaddr, output logic [3:0] m1_awlen,
  output logic [2:0] m1_awsize, output logic [1:0] m1_awburst, output logic [1:0] m1_awlock,
  output logic [3:0] m1_awcache, output logic [2:0] m1_awprot, output logic m1_awvalid, input logic m1_awready,
  output logic [ID_W-1:0] m1_wid, output logic [DATA_W-1:0] m1_wdata, output logic [DATA_W/8-1:0] m1_wstrb,
  output logic m1_wlast, output logic m1_wvalid, input logic m1_wready,
  input  logic [ID_W-1:0] m1_bid, input logic [1:0] m1_bresp, input logic m1_bvalid, output logic m1_bready,
  output logic [ID_W-1:0] m1_arid, output logic [ADDR_W-1:0] m1_araddr, output logic [3:0] m1_arlen,
  output logic [2:0] m1_arsize, output logic [1:0] m1_arburst, output logic [1:0] m1_arlock,
  output logic [3:0] m1_arcache, output logic [2:0] m1_arprot, output logic m1_arvalid, input logic m1_arready,
  input  logic [ID_W-1:0] m1_rid, input logic [DATA_W-1:0] m1_rdata, input logic [1:0] m1_rresp,
  input  logic m1_rlast, input logic m1_rvalid, output logic m1_rready
);

  // Packed address payload: {id, addr, len, size, burst, lock, cache, prot}.
  localparam int AX_W = ID_W + ADDR_W + L_LEN_W + L_SIZE_W + L_BURST_W + L_LOCK_W + L_CACHE_W + L_PROT_W;

  rd_state_t         rd_state_q, rd_state_d;
  wr_state_t         wr_state_q, wr_state_d;
  tgt_t              ar_tgt_q, ar_tgt_d, aw_tgt_q, aw_tgt_d, ar_tgt_new, aw_tgt_new;
  logic [AX_W-1:0]   ar_pl_q, ar_pl_d, aw_pl_q, aw_pl_d;
  logic [3:0]        rcnt_q, rcnt_d;
  logic              ar_hit0, ar_hit1, ar_err, aw_hit0, aw_hit1, aw_err;

  axi_addr_decode #(.ADDR_W(ADDR_W), .SRAM_BASE(SRAM_BASE), .SRAM_SIZE(SRAM_SIZE),
                    .MMIO_BASE(MMIO_BASE), .MMIO_SIZE(MMIO_SIZE))
    u_ar_dec (.addr(s_araddr), .hit0(ar_hit0), .hit1(ar_hit1), .err(ar_err));
  axi_addr_decode #(.ADDR_W(ADDR_W), .SRAM_BASE(SRAM_BASE), .SRAM_SIZE(SRAM_SIZE),
                    .MMIO_BASE(MMIO_BASE), .MMIO_SIZE(MMIO_SIZE))
    u_aw_dec (.addr(s_awaddr), .hit0(aw_hit0), .hit1(aw_hit1), .err(aw_err));

  assign ar_tgt_new = pick_target(ar_hit0, ar_hit1, ar_err);
  assign aw_tgt_new = pick_target(aw_hit0, aw_hit1, aw_err);

  // Registered payload goes to both ports; only the selected port sees valid.
  assign {m0_arid, m0_araddr, m0_arlen, m0_arsize, m0_arburst, m0_arlock, m0_arcache, m0_arprot} = ar_pl_q;
  assign {m1_arid, m1_araddr, m1_arlen, m1_arsize, m1_arburst, m1_arlock, m1_arcache, m1_arprot} = ar_pl_q;
  assign {m0_awid, m0_awaddr, m0_awlen, m0_awsize, m0_awburst, m0_awlock, m0_awcache, m0_awprot} = aw_pl_q;
  assign {m1_awid, m1_awaddr, m1_awlen, m1_awsize, m1_awburst, m1_awlock, m1_awcache, m1_awprot} = aw_pl_q;
  assign {m0_wid, m0_wdata, m0_wstrb, m0_wlast} = {s_wid, s_wdata, s_wstrb, s_wlast};
  assign {m1_wid, m1_wdata, m1_wstrb, m1_wlast} = {s_wid, s_wdata, s_wstrb, s_wlast};

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      rd_state_q <= RD_IDLE;
      wr_state_q <= WR_IDLE;
      ar_tgt_q   <= TGT_M0;
      aw_tgt_q   <= TGT_M0;
      ar_pl_q    <= '0;
      aw_pl_q    <= '0;
      rcnt_q     <= '0;
    end else begin
      rd_state_q <= rd_state_d;
      wr_state_q <= wr_state_d;
      ar_tgt_q   <= ar_tgt_d;
      aw_tgt_q   <= aw_tgt_d;
      ar_pl_q    <= ar_pl_d;
      aw_pl_q    <= aw_pl_d;
      rcnt_q     <= rcnt_d;
    end
  end

  // Read path
  always_comb begin
    rd_state_d = rd_state_q;
    ar_tgt_d   = ar_tgt_q;
    ar_pl_d    = ar_pl_q;
    rcnt_d     = rcnt_q;
    s_arready  = 1'b0;
    m0_arvalid = 1'b0;
    m1_arvalid = 1'b0;
    m0_rready  = 1'b0;
    m1_rready  = 1'b0;
    s_rvalid   = 1'b0;
    s_rid      = '0;
    s_rdata    = '0;
    s_rresp    = RESP_OKAY;
    s_rlast    = 1'b0;
    case (rd_state_q)
      RD_IDLE: begin
        s_arready = 1'b1;
        if (s_arvalid) begin
          ar_pl_d    = {s_arid, s_araddr, s_arlen, s_arsize, s_arburst, s_arlock, s_arcache, s_arprot};
          ar_tgt_d   = ar_tgt_new;
          rcnt_d     = s_arlen;
          rd_state_d = (ar_tgt_new == TGT_ERR) ? RD_ERR : RD_ADDR;
        end
      end
      RD_ADDR: begin
        if (ar_tgt_q == TGT_M0) begin
          m0_arvalid = 1'b1;
          if (m0_arready) rd_state_d = RD_DATA;
        end else begin
          m1_arvalid = 1'b1;
          if (m1_arready) rd_state_d = RD_DATA;
        end
      end
      RD_DATA: begin
        if (ar_tgt_q == TGT_M0) begin
          {s_rid, s_rdata, s_rresp, s_rlast, s_rvalid} = {m0_rid, m0_rdata, m0_rresp, m0_rlast, m0_rvalid};
          m0_rready = s_rready;
          if (m0_rvalid && s_rready && m0_rlast) rd_state_d = RD_IDLE;
        end else begin
          {s_rid, s_rdata, s_rresp, s_rlast, s_rvalid} = {m1_rid, m1_rdata, m1_rresp, m1_rlast, m1_rvalid};
          m1_rready = s_rready;
          if (m1_rvalid && s_rready && m1_rlast) rd_state_d = RD_IDLE;
        end
      end
      RD_ERR: begin
        // Counter holds the beats remaining after the current one; stops at zero.
        s_rvalid = 1'b1;
        s_rid    = ar_pl_q[AX_W-1 -: ID_W];
        s_rresp  = RESP_DECERR;
        s_rlast  = (rcnt_q == 4'd0);
        if (s_rready) begin
          if (rcnt_q == 4'd0) rd_state_d = RD_IDLE;
          else                rcnt_d     = rcnt_q - 4'd1;
        end
      end
      default: rd_state_d = RD_IDLE;
    endcase
  end

  // Write path
  always_comb begin
    wr_state_d = wr_state_q;
    aw_tgt_d   = aw_tgt_q;
    aw_pl_d    = aw_pl_q;
    s_awready  = 1'b0;
    s_wready   = 1'b0;
    m0_awvalid = 1'b0;
    m1_awvalid = 1'b0;
    m0_wvalid  = 1'b0;
    m1_wvalid  = 1'b0;
    m0_bready  = 1'b0;
    m1_bready  = 1'b0;
    s_bvalid   = 1'b0;
    s_bid      = '0;
    s_bresp    = RESP_OKAY;
    case (wr_state_q)
      WR_IDLE: begin
        s_awready = 1'b1;
        if (s_awvalid) begin
          aw_pl_d    = {s_awid, s_awaddr, s_awlen, s_awsize, s_awburst, s_awlock, s_awcache, s_awprot};
          aw_tgt_d   = aw_tgt_new;
          wr_state_d = (aw_tgt_new == TGT_ERR) ? WR_ERR : WR_ADDR;
        end
      end
      WR_ADDR: begin
        // W stays stalled (s_wready=0) until the downstream AW handshake.
        if (aw_tgt_q == TGT_M0) begin
          m0_awvalid = 1'b1;
          if (m0_awready) wr_state_d = WR_DATA;
        end else begin
          m1_awvalid = 1'b1;
          if (m1_awready) wr_state_d = WR_DATA;
        end
      end
      WR_DATA: begin
        if (aw_tgt_q == TGT_M0) begin
          m0_wvalid = s_wvalid;
          s_wready  = m0_wready;
        end else begin
          m1_wvalid = s_wvalid;
          s_wready  = m1_wready;
        end
        if (s_wvalid && s_wready && s_wlast) wr_state_d = WR_RESP;
      end
      WR_RESP: begin
        if (aw_tgt_q == TGT_M0) begin
          {s_bid, s_bresp, s_bvalid} = {m0_bid, m0_bresp, m0_bvalid};
          m0_bready = s_bready;
        end else begin
          {s_bid, s_bresp, s_bvalid} = {m1_bid, m1_bresp, m1_bvalid};
          m1_bready = s_bready;
        end
        if (s_bvalid && s_bready) wr_state_d = WR_IDLE;
      end
      WR_ERR: begin
        s_wready = 1'b1;
        if (s_wvalid && s_wlast) wr_state_d = WR_ERRB;
      end
      WR_ERRB: begin
        s_bvalid = 1'b1;
        s_bid    = aw_pl_q[AX_W-1 -: ID_W];
        s_bresp  = RESP_DECERR;
        if (s_bready) wr_state_d = WR_IDLE;
      end
      default: wr_state_d = WR_IDLE;
    endcase
  end

endmodule
